// File: rtl/xbus_pkg.sv
// Shared xbus definitions: slave count, master FSM states, address map and timeout default.
package xbus_pkg;

  localparam int NSLAVES      = 4;
  localparam int XBUS_TIMEOUT = 255;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } xbus_mst_state_t;

  // Decoder selects slave i when (addr & SLV_MASK) == SLV<i>_BASE.
  localparam logic [31:0] SLV_MASK  = 32'hF000_0000;
  localparam logic [31:0] SLV0_BASE = 32'h0000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV2_BASE = 32'h9000_0000;
  localparam logic [31:0] SLV3_BASE = 32'hA000_0000;

endpackage

// File: rtl/xbus_resp_mux.sv
// Combinational response mux: lowest-index chip select wins, its ack and rdata are forwarded.
module xbus_resp_mux
  import xbus_pkg::*;
#(
  parameter int NSLAVES = xbus_pkg::NSLAVES
) (
  input  logic [NSLAVES-1:0]    cs,
  input  logic [NSLAVES-1:0]    ack,
  input  logic [32*NSLAVES-1:0] rdata,
  output logic                  sel_ack,
  output logic [31:0]           sel_rdata,
  output logic                  none_sel
);

  logic [NSLAVES-1:0] sel_oh;

  always_comb begin
    sel_oh = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (cs[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    none_sel  = (cs == '0);
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel_oh[i]) begin
        sel_ack   = ack[i];
        sel_rdata = rdata[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/xbus_master.sv
// Single-outstanding xbus initiator: IDLE -> BUS (wait for selected ack / unmapped / timeout) -> RESP.
// Zero-wait access completes in 3 cycles; all outputs registered; cpu_req only sampled in IDLE.
module xbus_master
  import xbus_pkg::*;
#(
  parameter int NSLAVES = xbus_pkg::NSLAVES,
  parameter int TIMEOUT = XBUS_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [31:0]           cpu_rdata,
  output logic                  xbus_as,
  output logic [31:0]           xbus_addr,
  output logic                  xbus_we,
  output logic [31:0]           xbus_wdata,
  output logic [3:0]            xbus_be,
  input  logic [NSLAVES-1:0]    xbus_cs,
  input  logic [NSLAVES-1:0]    xbus_ack,
  input  logic [32*NSLAVES-1:0] xbus_rdata
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  xbus_mst_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d, as_q, as_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic        sel_ack, none_sel;
  logic [31:0] sel_rdata;

  xbus_resp_mux #(.NSLAVES(NSLAVES)) u_resp_mux (
    .cs        (xbus_cs),
    .ack       (xbus_ack),
    .rdata     (xbus_rdata),
    .sel_ack   (sel_ack),
    .sel_rdata (sel_rdata),
    .none_sel  (none_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = BUS;
      BUS:     if (none_sel || sel_ack || cnt_q == TMO_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; ack takes priority over timeout.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          be_d    = cpu_be;
        end
      end
      BUS: begin
        if (none_sel) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (sel_ack) begin
          err_d   = 1'b0;
          rdata_d = sel_rdata;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    as_d   = (state_d == BUS);
    busy_d = (state_d != IDLE);
    done_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      as_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      as_q    <= as_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cpu_busy   = busy_q;
  assign cpu_done   = done_q;
  assign cpu_err    = err_q;
  assign cpu_rdata  = rdata_q;
  assign xbus_as    = as_q;
  assign xbus_addr  = addr_q;
  assign xbus_we    = we_q;
  assign xbus_wdata = wdata_q;
  assign xbus_be    = be_q;

endmodule

// File: tb/tb_xbus_master.sv
// Directed vector bench for xbus_master with TIMEOUT=8 and a 4-slave bus model driven per cycle.
module tb_xbus_master;

  logic         clk, rst_n;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_busy, cpu_done, cpu_err;
  logic [31:0]  cpu_rdata;
  logic         xbus_as, xbus_we;
  logic [31:0]  xbus_addr, xbus_wdata;
  logic [3:0]   xbus_be;
  logic [3:0]   xbus_cs, xbus_ack;
  logic [127:0] xbus_rdata;

  int n_pass = 0;
  int n_tot  = 0;

  xbus_master #(.NSLAVES(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_be     (cpu_be),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .xbus_as    (xbus_as),
    .xbus_addr  (xbus_addr),
    .xbus_we    (xbus_we),
    .xbus_wdata (xbus_wdata),
    .xbus_be    (xbus_be),
    .xbus_cs    (xbus_cs),
    .xbus_ack   (xbus_ack),
    .xbus_rdata (xbus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  cs;
    int          a1_cyc;
    logic [3:0]  a1_vec;
    int          a2_cyc;
    logic [3:0]  a2_vec;
    logic [31:0] rd0;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                              logic [3:0] cs, int a1c, logic [3:0] a1v, int a2c, logic [3:0] a2v,
                              logic [31:0] rd0, int ec, logic ee, logic [31:0] er);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.cs = cs;
    v.a1_cyc = a1c; v.a1_vec = a1v; v.a2_cyc = a2c; v.a2_vec = a2v;
    v.rd0 = rd0; v.exp_cyc = ec; v.exp_err = ee; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Starts at a falling edge; cycle c is the c-th cycle after the sampling edge.
  task automatic run(input int id, input vec_t v);
    int   done_at = 0;
    int   as_n    = 0;
    int   busy_n  = 0;
    logic stable  = 1'b1;
    logic fin     = 1'b0;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_be = v.be;
    xbus_cs = '0; xbus_ack = '0;
    xbus_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, v.rd0};
    @(posedge clk);
    for (int c = 1; c <= 40 && !fin; c++) begin
      #1;
      cpu_req = 1'b0;
      cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; cpu_be = ~v.be; cpu_we = ~v.we;
      if (done_at == 0) begin
        xbus_cs  = v.cs;
        xbus_ack = ((c == v.a1_cyc) ? v.a1_vec : 4'b0) | ((c == v.a2_cyc) ? v.a2_vec : 4'b0);
      end else begin
        xbus_cs = '0; xbus_ack = '0;
      end
      @(negedge clk);
      if (xbus_as) as_n++;
      if (cpu_busy) busy_n++;
      if (xbus_as && (xbus_addr !== v.addr || xbus_wdata !== v.wdata ||
                      xbus_be !== v.be || xbus_we !== v.we)) stable = 1'b0;
      if (done_at != 0) begin
        fin = 1'b1;
        chk($sformatf("v%0d_done_pulse", id), 32'(cpu_done), 32'd0);
        if (!v.we) chk($sformatf("v%0d_rdata_hold", id), cpu_rdata, v.exp_rd);
      end else if (cpu_done) begin
        done_at = c;
        chk($sformatf("v%0d_err", id), 32'(cpu_err), 32'(v.exp_err));
        if (!v.we) chk($sformatf("v%0d_rdata", id), cpu_rdata, v.exp_rd);
      end
      if (!fin) @(posedge clk);
    end
    if (!fin) @(negedge clk);
    chk($sformatf("v%0d_done_cycle", id), 32'(done_at), 32'(v.exp_cyc));
    chk($sformatf("v%0d_as_cycles", id), 32'(as_n), 32'(v.exp_cyc - 1));
    chk($sformatf("v%0d_busy_cycles", id), 32'(busy_n), 32'(v.exp_cyc));
    chk($sformatf("v%0d_bus_stable", id), 32'(stable), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    xbus_cs = '0; xbus_ack = '0; xbus_rdata = '0;

    //             we    addr          wdata         be       cs       a1c a1v      a2c a2v      rd0           cyc err exp_rd
    vecs[0] = mk(1'b0, 32'h0000_0010, 32'h0,        4'b1111, 4'b0001, 1, 4'b0001, 0, 4'b0000, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF);
    vecs[1] = mk(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 4'b0010, 4, 4'b0010, 0, 4'b0000, 32'h0,        5, 1'b0, 32'h0);
    vecs[2] = mk(1'b0, 32'h4000_0000, 32'h0,        4'b1111, 4'b0000, 1, 4'b0001, 0, 4'b0000, 32'h7777_7777, 2, 1'b1, 32'h0);
    vecs[3] = mk(1'b0, 32'h0000_0100, 32'h0,        4'b1111, 4'b0001, 0, 4'b0000, 0, 4'b0000, 32'h5555_5555, 9, 1'b1, 32'h0);
    vecs[4] = mk(1'b0, 32'h0000_0200, 32'h0,        4'b1111, 4'b0001, 1, 4'b0010, 3, 4'b0001, 32'hA5A5_A5A5, 4, 1'b0, 32'hA5A5_A5A5);
    vecs[5] = mk(1'b0, 32'h0000_0300, 32'h0,        4'b0001, 4'b0001, 8, 4'b0001, 0, 4'b0000, 32'h0BAD_F00D, 9, 1'b0, 32'h0BAD_F00D);
    vecs[6] = mk(1'b0, 32'h8000_0040, 32'h0,        4'b1100, 4'b0110, 1, 4'b0100, 2, 4'b0010, 32'hCCCC_CCCC, 3, 1'b0, 32'h1111_1111);

    #3;
    chk("rst_ctrl", 32'({xbus_as, cpu_busy, cpu_done, cpu_err, xbus_we}), 32'd0);
    chk("rst_addr", xbus_addr, 32'd0);
    chk("rst_wdata", xbus_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_be", 32'(xbus_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(i, vecs[i]);

    // Reset dropped during the second BUS cycle of a load.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_be = 4'b1111;
    xbus_cs = '0; xbus_ack = '0;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    xbus_cs = 4'b0001;
    @(posedge clk);
    #2;
    chk("rst_mid_as_before", 32'(xbus_as), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_as", 32'(xbus_as), 32'd0);
    chk("rst_mid_busy", 32'(cpu_busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_no_done%0d", k), 32'(cpu_done), 32'd0);
    end
    xbus_cs = '0;
    rst_n = 1'b1;
    run(7, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
